// File: rtl/reg_file.sv
// reg_file: 32 x 32-bit architectural register file for the single-cycle CPU.
// Two combinational read ports (rs, rt) and one synchronous write port (rd).
// r0 reads as zero and ignores writes; r29 (stack pointer) resets to SP_RESET.
// Optional macro REG_FILE_BYPASS_EN: forward a same-cycle write to either read port.

module reg_file #(
    parameter logic [31:0] SP_RESET = 32'd128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    input  logic        reg_write_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o
);

    localparam int unsigned SpIdx = 29;

    // r0 has no storage; it is synthesised as a constant zero on the read side.
    logic [31:0] regs_q [1:31];

    logic        wr_en;
    logic [31:0] rs_stored;
    logic [31:0] rt_stored;

    // Write qualifier: a reset in the same cycle discards the write.
    always_comb begin
        wr_en = reg_write_i && !rst_i && (rd_addr_i != 5'd0);
    end

    // Register storage: asynchronous clear to reset contents, single write per edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= (i == SpIdx) ? SP_RESET : 32'h0;
            end
        end else if (wr_en) begin
            regs_q[rd_addr_i] <= rd_data_i;
        end
    end

    // Stored-value lookup for both ports; address 0 returns the hardwired zero.
    always_comb begin
        rs_stored = 32'h0;
        rt_stored = 32'h0;
        if (rs_addr_i != 5'd0) begin
            rs_stored = regs_q[rs_addr_i];
        end
        if (rt_addr_i != 5'd0) begin
            rt_stored = regs_q[rt_addr_i];
        end
    end

`ifdef REG_FILE_BYPASS_EN
    // Output select: forward the in-flight write data when it targets the read index.
    always_comb begin
        rs_data_o = rs_stored;
        rt_data_o = rt_stored;
        if (wr_en && (rd_addr_i == rs_addr_i)) begin
            rs_data_o = rd_data_i;
        end
        if (wr_en && (rd_addr_i == rt_addr_i)) begin
            rt_data_o = rd_data_i;
        end
    end
`else
    // Output select: reads always return the committed register contents.
    always_comb begin
        rs_data_o = rs_stored;
        rt_data_o = rt_stored;
    end
`endif

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed steps, expectations queued in a
// scoreboard at drive time and popped when the read ports are sampled.

module tb_reg_file;

`ifdef REG_FILE_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        reg_write;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;

    exp_t sb[$];

    reg_file #(
        .SP_RESET (32'd128)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .rs_addr_i   (rs_addr),
        .rt_addr_i   (rt_addr),
        .rd_addr_i   (rd_addr),
        .rd_data_i   (rd_data),
        .reg_write_i (reg_write),
        .rs_data_o   (rs_data),
        .rt_data_o   (rt_data)
    );

    // Gated clock so the reset phase can be exercised with no edges at all.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic expect_rd(input string tag, input logic [31:0] ers, input logic [31:0] ert);
        exp_t e;
        e.tag = tag;
        e.rs  = ers;
        e.rt  = ert;
        sb.push_back(e);
    endtask

    task automatic compare_rd();
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got=%0d required=1", sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            assert (rs_data === e.rs) else begin
                errors++;
                $error("FAIL %s rs_data got=%h required=%h", e.tag, rs_data, e.rs);
            end
            assert (rt_data === e.rt) else begin
                errors++;
                $error("FAIL %s rt_data got=%h required=%h", e.tag, rt_data, e.rt);
            end
        end
    endtask

    // Queue an expectation, let the combinational read settle, then compare.
    task automatic probe(input string tag, input logic [31:0] ers, input logic [31:0] ert);
        expect_rd(tag, ers, ert);
        #1;
        compare_rd();
    endtask

    task automatic set_rd(input logic [4:0] a, input logic [4:0] b);
        rs_addr = a;
        rt_addr = b;
    endtask

    task automatic set_wr(input logic we, input logic [4:0] a, input logic [31:0] d);
        reg_write = we;
        rd_addr   = a;
        rd_data   = d;
    endtask

    initial begin
        clk = 1'b0;
        clk_en = 1'b0;
        rst = 1'b1;
        set_rd(5'd0, 5'd0);
        set_wr(1'b0, 5'd0, 32'h0);

        // Reset contents with no clock: sweep every index on both ports.
        #2;
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            probe("reset_sweep", (i == 29) ? 32'd128 : 32'h0,
                  ((31 - i) == 29) ? 32'd128 : 32'h0);
        end
        rst = 1'b0;
        set_rd(5'd29, 5'd7);
        probe("reset_release_hold", 32'd128, 32'h0);

        clk_en = 1'b1;
        @(negedge clk);

        // Basic write of r8, read on both ports.
        set_wr(1'b1, 5'd8, 32'hDEADBEEF);
        set_rd(5'd8, 5'd8);
        probe("w8_same_cycle", Byp ? 32'hDEADBEEF : 32'h0, Byp ? 32'hDEADBEEF : 32'h0);
        @(negedge clk);
        set_wr(1'b0, 5'd9, 32'h12345678);
        probe("w8_read", 32'hDEADBEEF, 32'hDEADBEEF);
        set_rd(5'd9, 5'd8);
        @(negedge clk);
        probe("w9_disabled", 32'h0, 32'hDEADBEEF);

        // r0 protection.
        set_wr(1'b1, 5'd0, 32'hFFFFFFFF);
        set_rd(5'd0, 5'd0);
        probe("r0_write_cycle", 32'h0, 32'h0);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        probe("r0_after_1", 32'h0, 32'h0);
        @(negedge clk);
        probe("r0_after_2", 32'h0, 32'h0);

        // Same-cycle collision on r5.
        set_wr(1'b1, 5'd5, 32'h1);
        set_rd(5'd0, 5'd0);
        @(negedge clk);
        set_wr(1'b1, 5'd5, 32'h2);
        set_rd(5'd5, 5'd5);
        probe("collide_before_edge", Byp ? 32'h2 : 32'h1, Byp ? 32'h2 : 32'h1);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        probe("collide_after_edge", 32'h2, 32'h2);

        // Dual-port independence while writing r31.
        set_rd(5'd0, 5'd0);
        set_wr(1'b1, 5'd1, 32'h11);
        @(negedge clk);
        set_wr(1'b1, 5'd2, 32'h22);
        @(negedge clk);
        set_wr(1'b1, 5'd31, 32'h7);
        set_rd(5'd1, 5'd2);
        probe("dual_port", 32'h11, 32'h22);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd31, 5'd31);
        probe("r31_next_cycle", 32'h7, 32'h7);

        // Reset raised in the same cycle as a write to r3.
        set_wr(1'b1, 5'd3, 32'h55);
        set_rd(5'd0, 5'd0);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        set_rd(5'd3, 5'd3);
        probe("r3_preset", 32'h55, 32'h55);
        @(negedge clk);
        set_wr(1'b1, 5'd3, 32'hAA);
        rst = 1'b1;
        probe("rst_midwrite_now", 32'h0, 32'h0);
        @(posedge clk);
        probe("rst_midwrite_edge", 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0);
        probe("rst_midwrite_after", 32'h0, 32'h0);
        set_rd(5'd8, 5'd31);
        probe("rst_cleared_others", 32'h0, 32'h0);

        // r29 overwritten, then an unclocked reset pulse restores it.
        set_wr(1'b1, 5'd29, 32'h10);
        set_rd(5'd29, 5'd29);
        probe("w29_same_cycle", Byp ? 32'h10 : 32'd128, Byp ? 32'h10 : 32'd128);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        probe("w29_read", 32'h10, 32'h10);
        #1;
        rst = 1'b1;
        probe("rst_pulse_sp", 32'd128, 32'd128);
        rst = 1'b0;
        probe("rst_pulse_release", 32'd128, 32'd128);

        // First edge after reset release writes normally.
        @(negedge clk);
        set_wr(1'b1, 5'd4, 32'hCAFE0004);
        set_rd(5'd4, 5'd29);
        @(negedge clk);
        set_wr(1'b0, 5'd0, 32'h0);
        probe("post_reset_write", 32'hCAFE0004, 32'd128);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file for the single-cycle CPU: 32 general-purpose 32-bit registers with two combinational read ports and one synchronous write port. It sits directly upstream of the ALU. The rs and rt read ports drive the ALU's two 32-bit source operands, and the write port takes the writeback result (ALU result or load data) selected by the datapath. Register 0 is hardwired to zero. The stack pointer (register 29) has a non-zero reset value.

## Interface
Parameters:
- `SP_RESET`, default 32'd128: reset value of register 29 (stack pointer).

Ports:
- `clk_i`  input  1  clock; all writes occur on its rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `rs_addr_i`  input  5  read port A index (instruction rs field).
- `rt_addr_i`  input  5  read port B index (instruction rt field).
- `rd_addr_i`  input  5  write index (rd or rt, chosen upstream by the RegDst mux).
- `rd_data_i`  input  32  write data.
- `reg_write_i`  input  1  write enable, sampled on the rising edge of `clk_i`.
- `rs_data_o`  output  32  read port A data; feeds ALU source 1.
- `rt_data_o`  output  32  read port B data; feeds ALU source 2 or the store-data path.

## Operation
- Storage is 32 x 32-bit registers, r0 to r31.
- Reads are purely combinational from the address to the data output, with no clock involved. Both ports may address the same register.
- Writes: on the rising edge of `clk_i`, if `reg_write_i`=1, `rst_i`=0 and `rd_addr_i`≠0, then register[`rd_addr_i`] ← `rd_data_i`. Otherwise no register changes.
- Register 0 rules:
  - Reading r0 always returns 32'h0.
  - Writes to r0 are silently dropped, and no flag is raised.
- Reset: while `rst_i`=1, r29 = `SP_RESET` and every other register = 32'h0. The clear takes effect immediately and does not wait for a clock edge.
- Output values under reset:
  - Both read outputs reflect the reset contents combinationally.
  - They are therefore 32'h0, or `SP_RESET` when the port addresses r29.
- Reset mid-operation: asserting `rst_i` in the same cycle as a pending write discards the write. After `rst_i` deasserts, the first edge that can write is the first rising edge of `clk_i` with `rst_i` low.
- Write-through bypass (only when `REG_FILE_BYPASS_EN` is defined):
  - If `reg_write_i`=1, `rst_i`=0, `rd_addr_i`≠0 and `rd_addr_i` equals a read address, that port returns `rd_data_i` in the same cycle instead of the stored value.
  - This applies to each port independently; both ports may bypass at once.
- There are no width conversions. Data is stored and returned unmodified, and there are no sign or zero extension rules in this block.

## Timing
- Read latency is 0 cycles (combinational). The path address → data → ALU → writeback mux → `rd_data_i` must close within one clock period.
- Write latency is 1 edge. Data presented in cycle N becomes visible on the read ports in cycle N+1, or in cycle N when the bypass is enabled.
- Simultaneous read and write of the same register:
  - Without the bypass, the read returns the old value until the edge, then the new value.
  - With the bypass, the read returns the new value throughout cycle N.
- Reset is asynchronous. The outputs follow the reset values within the same cycle that `rst_i` rises, with no clock required.
- There is no handshake. `reg_write_i` is a level-sampled enable, with a single write per edge.

## Configuration
- `REG_FILE_BYPASS_EN` defined: the same-cycle write-to-read forwarding described under Operation is compiled in on both read ports.
- `REG_FILE_BYPASS_EN` undefined: the bypass mux is not built, and reads always return stored contents. This is the default for the single-cycle CPU, where the write commits at the end of the instruction.

## Test plan
- Reset values: assert `rst_i` with no clock, read every index on both ports → r29 = 32'd128 on both ports; all other registers = 32'h0. Deassert `rst_i`; the values hold.
- Basic write/read: write r8 ← 32'hDEADBEEF with `reg_write_i`=1, then on the next cycle set `rs_addr_i`=8, `rt_addr_i`=8 → both ports = 32'hDEADBEEF. Write r9 with `reg_write_i`=0 → r9 stays 32'h0.
- r0 protection: write r0 ← 32'hFFFFFFFF → reading r0 on either port returns 32'h0 on every following cycle.
- Same-cycle collision: r5 = 32'h1; in one cycle write r5 ← 32'h2 and read r5 on both ports.
  - Without the macro: 32'h1 before the edge, 32'h2 after.
  - With `REG_FILE_BYPASS_EN`: 32'h2 within the same cycle.
- Reset mid-write: r3 = 32'h55; raise `rst_i` in the same cycle as a write r3 ← 32'hAA → r3 reads 32'h0 immediately and after the edge. Write r29 ← 32'h10, then pulse `rst_i` between clock edges → r29 reads 32'd128 without a clock edge.
- Dual-port independence: r1 = 32'h11 and r2 = 32'h22; set `rs_addr_i`=1 and `rt_addr_i`=2 while writing r31 ← 32'h7 → outputs are 32'h11 and 32'h22, and r31 reads 32'h7 on the next cycle.
